// File: rtl/hypot_sqrt_engine.sv
// Integer Euclidean magnitude floor(sqrt(x^2+y^2[+z^2])) with remainder and exact flag.
// One restoring square-root digit per clock behind a start/busy/done handshake.
module hypot_sqrt_engine #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode3d,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic         busy,
  output logic         done,
  output logic [W:0]   result,
  output logic [W+1:0] rem,
  output logic         exact
);

  localparam int SW = 2*W + 2;          // sum of squares width
  localparam int PW = W + 4;            // partial remainder incl. two shifted-in bits
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SUM, ROOT} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   xr, yr, zr;
  logic           m3;
  logic [SW-1:0]  sum_sq, s_reg;
  logic [W:0]     root, root_nxt;
  logic [PW-1:0]  part, part_sh, trial, part_nxt;
  logic [CW-1:0]  cnt;
  logic [1:0]     pair;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SUM;
      SUM:     state_nxt = ROOT;
      ROOT:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum_sq = SW'(xr) * SW'(xr) + SW'(yr) * SW'(yr);
    if (m3) sum_sq = sum_sq + SW'(zr) * SW'(zr);
  end

  // One restoring digit: bring down the next bit pair of S, try subtracting (root<<2)|1.
  always_comb begin
    pair    = 2'(s_reg >> {cnt, 1'b0});
    part_sh = {part[PW-3:0], pair};
    trial   = PW'({root, 2'b01});
    if (part_sh >= trial) begin
      part_nxt = part_sh - trial;
      root_nxt = {root[W-1:0], 1'b1};
    end else begin
      part_nxt = part_sh;
      root_nxt = {root[W-1:0], 1'b0};
    end
  end

  // NOTE: working registers carry no reset; each is loaded before it is ever read.
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: if (start) begin
        xr <= x;
        yr <= y;
        zr <= z;
        m3 <= mode3d;
      end
      SUM: begin
        s_reg <= sum_sq;
        root  <= '0;
        part  <= '0;
        cnt   <= CW'(W);
      end
      ROOT: begin
        root <= root_nxt;
        part <= part_nxt;
        cnt  <= cnt - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rem    <= '0;
      exact  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) busy <= 1'b1;
      if (state == ROOT && cnt == '0) begin
        result <= root_nxt;
        rem    <= part_nxt[W+1:0];
        exact  <= (part_nxt == '0);
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hypot_sqrt_engine.sv
// Self-checking bench: four engines (W=8,4,12,16) driven in lockstep and compared against
// a real-arithmetic integer square root reference; directed W=8 cases plus random sweep.
module tb_hypot_sqrt_engine;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, mode3d;
  logic [15:0] xa [NI];
  logic [15:0] ya [NI];
  logic [15:0] za [NI];
  wire         busy_a  [NI];
  wire         done_a  [NI];
  wire         exact_a [NI];
  wire  [16:0] res_a   [NI];
  wire  [17:0] rem_a   [NI];

  int          total = 0;
  int          bad   = 0;
  int          lat   [NI];
  logic [63:0] got_r [NI];
  logic [63:0] got_m [NI];
  logic [63:0] got_e [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WG = (g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 12 : 16;
    logic [WG:0]   r;
    logic [WG+1:0] m;
    hypot_sqrt_engine #(.W(WG)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .mode3d (mode3d),
      .x      (xa[g][WG-1:0]),
      .y      (ya[g][WG-1:0]),
      .z      (za[g][WG-1:0]),
      .busy   (busy_a[g]),
      .done   (done_a[g]),
      .result (r),
      .rem    (m),
      .exact  (exact_a[g])
    );
    assign res_a[g] = 17'(r);
    assign rem_a[g] = 18'(m);
  end

  function automatic int wof(input int g);
    return (g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 12 : 16;
  endfunction

  function automatic logic [15:0] msk(input int w);
    return 16'((32'h1 << w) - 1);
  endfunction

  function automatic longint isqrt(input longint s);
    longint r = longint'($floor($sqrt(real'(s))));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One transaction on all engines; each is checked against the reference model.
  task automatic op(input logic [15:0] xi, yi, zi, input logic m, input bit noise);
    int     ndone [NI];
    int     both = 0;
    longint xm, ym, zm, s, r;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      xa[g] = xi & msk(wof(g));
      ya[g] = yi & msk(wof(g));
      za[g] = zi & msk(wof(g));
      lat[g] = -1;
      ndone[g] = 0;
    end
    mode3d = m;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    mode3d = ~m;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("busy_after_accept_w%0d", wof(g)), 64'(busy_a[g]), 64'd1);
      xa[g] = 16'($urandom);
      ya[g] = 16'($urandom);
      za[g] = 16'($urandom);
    end
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk);
      @(negedge clk);
      start = (noise && (e == 3 || e == 5));
      for (int g = 0; g < NI; g++) begin
        if (busy_a[g] && done_a[g]) both++;
        if (done_a[g]) begin
          ndone[g]++;
          if (lat[g] < 0) begin
            lat[g]   = e;
            got_r[g] = 64'(res_a[g]);
            got_m[g] = 64'(rem_a[g]);
            got_e[g] = 64'(exact_a[g]);
          end
        end
      end
    end
    start = 1'b0;
    for (int g = 0; g < NI; g++) begin
      xm = longint'(xi & msk(wof(g)));
      ym = longint'(yi & msk(wof(g)));
      zm = longint'(zi & msk(wof(g)));
      s  = xm * xm + ym * ym + (m ? zm * zm : 0);
      r  = isqrt(s);
      check($sformatf("latency_w%0d", wof(g)), 64'(lat[g]), 64'(wof(g) + 2));
      check($sformatf("done_count_w%0d", wof(g)), 64'(ndone[g]), 64'd1);
      check($sformatf("result_w%0d_s%0d", wof(g), s), got_r[g], 64'(r));
      check($sformatf("rem_w%0d_s%0d", wof(g), s), got_m[g], 64'(s - r * r));
      check($sformatf("exact_w%0d_s%0d", wof(g), s), got_e[g], 64'(s == r * r));
      check($sformatf("lower_bound_w%0d", wof(g)), 64'(got_r[g] * got_r[g] <= 64'(s)), 64'd1);
      check($sformatf("upper_bound_w%0d", wof(g)), 64'((got_r[g] + 1) * (got_r[g] + 1) > 64'(s)), 64'd1);
    end
    check("busy_done_overlap", 64'(both), 64'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},   64'(busy_a[0]),  64'd0);
    check({tag, "_done"},   64'(done_a[0]),  64'd0);
    check({tag, "_result"}, 64'(res_a[0]),   64'd0);
    check({tag, "_rem"},    64'(rem_a[0]),   64'd0);
    check({tag, "_exact"},  64'(exact_a[0]), 64'd0);
  endtask

  initial begin
    int cyc [$];
    int high, nd;

    rst_n = 1'b0; start = 1'b0; mode3d = 1'b0;
    for (int g = 0; g < NI; g++) begin xa[g] = '0; ya[g] = '0; za[g] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    op(16'd3, 16'd4, 16'd0, 1'b0, 1'b0);
    check("d_3_4_result", got_r[0], 64'd5);
    check("d_3_4_rem", got_m[0], 64'd0);
    check("d_3_4_exact", got_e[0], 64'd1);
    op(16'd5, 16'd12, 16'd0, 1'b0, 1'b0);
    check("d_5_12_result", got_r[0], 64'd13);
    check("d_5_12_exact", got_e[0], 64'd1);
    op(16'd2, 16'd3, 16'd6, 1'b1, 1'b0);
    check("d_3d_result", got_r[0], 64'd7);
    check("d_3d_exact", got_e[0], 64'd1);
    op(16'd3, 16'd4, 16'd100, 1'b0, 1'b0);
    check("d_z_ignored_result", got_r[0], 64'd5);
    op(16'd255, 16'd255, 16'd0, 1'b0, 1'b0);
    check("d_max2d_result", got_r[0], 64'd360);
    check("d_max2d_rem", got_m[0], 64'd450);
    check("d_max2d_exact", got_e[0], 64'd0);
    op(16'd255, 16'd255, 16'd255, 1'b1, 1'b0);
    check("d_max3d_result", got_r[0], 64'd441);
    check("d_max3d_rem", got_m[0], 64'd594);
    op(16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    check("d_zero_result", got_r[0], 64'd0);
    check("d_zero_rem", got_m[0], 64'd0);
    check("d_zero_exact", got_e[0], 64'd1);
    op(16'd7, 16'd9, 16'd11, 1'b1, 1'b1);
    check("d_start_ignored_result", got_r[0], 64'd15);

    // start held high: one result every W+3 cycles, each done a single cycle wide
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin xa[g] = 16'd3; ya[g] = 16'd4; za[g] = 16'd0; end
    mode3d = 1'b0;
    start  = 1'b1;
    high   = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_a[0]) begin
        high++;
        if (cyc.size() == 0 || cyc[$] != i - 1) cyc.push_back(i);
        check("held_result", 64'(res_a[0]), 64'd5);
      end
    end
    start = 1'b0;
    check("held_done_pulses", 64'(cyc.size()), 64'd5);
    check("held_done_width", 64'(high), 64'(cyc.size()));
    if (cyc.size() > 0) check("held_first_done", 64'(cyc[0]), 64'd11);
    for (int k = 1; k < cyc.size(); k++) check("held_interval", 64'(cyc[k] - cyc[k-1]), 64'd11);
    repeat (25) @(posedge clk);

    // reset asserted for one edge at N+5 discards the computation
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin xa[g] = 16'd10; ya[g] = 16'd20; za[g] = 16'd0; end
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_zero("midreset");
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) if (done_a[g] || busy_a[g]) nd++;
    end
    check("midreset_no_activity", 64'(nd), 64'd0);
    op(16'd6, 16'd8, 16'd0, 1'b0, 1'b0);
    check("after_reset_result", got_r[0], 64'd10);

    repeat (40) op(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
